// File: rtl/cpu_mem_bridge.sv
// cpu_mem_bridge: connects the 16-bit CPU memory port to two targets.
// Requests are decoded by byte address. Addresses below IO_BASE go to the
// on-chip synchronous RAM; the rest go to an I/O slave with waitrequest.
// Stalled I/O accesses are aborted after TIMEOUT cycles and set a sticky
// bus error.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | accepting requests; RAM writes complete here in a single cycle
// RAM_RD | RAM data for the registered word address is passed to the CPU
// IO_ACC | I/O strobe held until the slave releases it or the timer expires
// DONE   | one-cycle I/O completion; o_cpu_rddata holds the captured value
module cpu_mem_bridge #(
    parameter int unsigned RAM_AW   = 12,
    parameter logic [15:0] IO_BASE  = 16'hF000,
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [15:0] ERR_DATA = 16'hDEAD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       i_cpu_addr,
    input  logic              i_cpu_rd,
    input  logic              i_cpu_wr,
    input  logic [15:0]       i_cpu_wrdata,
    output logic [15:0]       o_cpu_rddata,
    output logic              o_cpu_waitrequest,
    output logic [RAM_AW-1:0] o_ram_addr,
    output logic              o_ram_we,
    output logic [15:0]       o_ram_wrdata,
    input  logic [15:0]       i_ram_rddata,
    output logic [15:0]       o_io_addr,
    output logic              o_io_rd,
    output logic              o_io_wr,
    output logic [15:0]       o_io_wrdata,
    input  logic [15:0]       i_io_rddata,
    input  logic              i_io_waitrequest,
    input  logic              i_err_clr,
    output logic              o_bus_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RAM_RD = 2'd1,
        IO_ACC = 2'd2,
        DONE   = 2'd3
    } state_t;

    // The counter reaches TIMEOUT on the stalled cycle where it currently
    // holds TIMEOUT-1, so that value is the abort point.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t              state_q;
    logic [RAM_AW-1:0]   ram_addr_q;
    logic [15:0]         io_addr_q;
    logic [15:0]         io_wrdata_q;
    logic                io_rd_q;
    logic                io_wr_q;
    logic [15:0]         cpu_rddata_q;
    logic [15:0]         to_cnt_q;
    logic                bus_err_q;
    logic                bus_err_d;

    logic                in_idle;
    logic                sel_io;
    logic                req_any;
    logic                req_ill;
    logic                accept_ram_wr;
    logic                accept_ram_rd;
    logic                accept_io;
    logic                timeout_hit;
    logic                err_set;

    // Request decode. When rd and wr are both high the access is a write.
    always_comb begin
        in_idle       = (state_q == IDLE);
        sel_io        = (i_cpu_addr >= IO_BASE);
        req_any       = i_cpu_rd | i_cpu_wr;
        req_ill       = i_cpu_rd & i_cpu_wr;
        accept_ram_wr = in_idle & i_cpu_wr & ~sel_io;
        accept_ram_rd = in_idle & i_cpu_rd & ~i_cpu_wr & ~sel_io;
        accept_io     = in_idle & req_any & sel_io;
        timeout_hit   = (state_q == IO_ACC) & i_io_waitrequest & (to_cnt_q == TO_LAST);
        err_set       = (in_idle & req_ill) | timeout_hit;
    end

    // Sticky error next-state; a new error wins over a simultaneous clear.
    always_comb begin
        bus_err_d = bus_err_q;
        if (i_err_clr) begin
            bus_err_d = 1'b0;
        end
        if (err_set) begin
            bus_err_d = 1'b1;
        end
    end

    // CPU-facing and RAM-facing outputs. RAM writes and the first read cycle
    // are driven straight from the CPU port; RAM_RD uses the latched address.
    always_comb begin
        o_ram_addr   = in_idle ? i_cpu_addr[RAM_AW:1] : ram_addr_q;
        o_ram_we     = accept_ram_wr;
        o_ram_wrdata = i_cpu_wrdata;
        o_cpu_rddata = (state_q == RAM_RD) ? i_ram_rddata : cpu_rddata_q;
        unique case (state_q)
            IDLE:    o_cpu_waitrequest = accept_ram_rd | accept_io;
            RAM_RD:  o_cpu_waitrequest = 1'b0;
            IO_ACC:  o_cpu_waitrequest = 1'b1;
            DONE:    o_cpu_waitrequest = 1'b0;
            default: o_cpu_waitrequest = 1'b0;
        endcase
    end

    assign o_io_addr   = io_addr_q;
    assign o_io_wrdata = io_wrdata_q;
    assign o_io_rd     = io_rd_q;
    assign o_io_wr     = io_wr_q;
    assign o_bus_err   = bus_err_q;

    // Main sequencer with registered I/O strobes, I/O latches and read data.
    // Reset clears the strobes asynchronously, abandoning any access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            ram_addr_q   <= '0;
            io_addr_q    <= '0;
            io_wrdata_q  <= '0;
            io_rd_q      <= 1'b0;
            io_wr_q      <= 1'b0;
            cpu_rddata_q <= '0;
            to_cnt_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept_ram_rd) begin
                        ram_addr_q <= i_cpu_addr[RAM_AW:1];
                        state_q    <= RAM_RD;
                    end else if (accept_io) begin
                        io_addr_q   <= i_cpu_addr;
                        io_wrdata_q <= i_cpu_wrdata;
                        io_rd_q     <= ~i_cpu_wr;
                        io_wr_q     <= i_cpu_wr;
                        to_cnt_q    <= '0;
                        state_q     <= IO_ACC;
                    end
                end
                RAM_RD: begin
                    // Keep the RAM word visible after the pass-through cycle.
                    cpu_rddata_q <= i_ram_rddata;
                    state_q      <= IDLE;
                end
                IO_ACC: begin
                    if (!i_io_waitrequest) begin
                        io_rd_q <= 1'b0;
                        io_wr_q <= 1'b0;
                        if (io_rd_q) begin
                            cpu_rddata_q <= i_io_rddata;
                        end
                        state_q <= DONE;
                    end else if (to_cnt_q == TO_LAST) begin
                        // Abort: an aborted write is simply dropped.
                        io_rd_q <= 1'b0;
                        io_wr_q <= 1'b0;
                        if (io_rd_q) begin
                            cpu_rddata_q <= ERR_DATA;
                        end
                        state_q <= DONE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 16'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Sticky bus error register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= bus_err_d;
        end
    end

endmodule
